config_reg_bank: RTL and testbench
==================================

// Module: config_reg_bank
// PURPOSE
//  Parametrised trigger-board configuration register bank; successor to the fixed-map config block.
//  Decodes host writes into REG_NUM x DATA_W registers and provides registered readback.
//  Generates trigger/data-transfer enables and fixed-length command pulses.
//  Locks trigger-path registers while triggering is enabled.
//  Counts accepted and rejected writes.
//  Sits between the command decoder and the trigger logic / hit-alignment blocks.
// PARAMETERS
//  DATA_W     16              register width
//  ADDR_W     8               address width
//  REG_NUM    20              number of registers (index 0 = CTRL, index 1 = CMD, min 2)
//  BASE_ADDR  8'h02           address of index 0
//  PULSE_LEN  50              cmd pulse length in clk_in cycles (1..255)
//  LOCK_MASK  20'h000FC       bit i=1: index i is locked while trg_enb_out=1; bits 0,1 ignored
//  RST_VAL    {REG_NUM*DATA_W{1'b0}}  flat reset values, index i at [i*DATA_W +: DATA_W]
// PORTS
//  clk_in              in   1                 clock
//  rst_n_in            in   1                 reset, asynchronous, active-low
//  wr_in               in   1                 write strobe, one word per high cycle
//  wr_addr_in          in   ADDR_W            write address
//  data_in             in   DATA_W            write data
//  rd_in               in   1                 read strobe
//  rd_addr_in          in   ADDR_W            read address
//  rd_data_out         out  DATA_W            read data
//  rd_valid_out        out  1                 read data valid, 1-cycle pulse
//  rd_err_out          out  1                 read address out of range; valid with rd_valid_out
//  regs_out            out  REG_NUM*DATA_W    active register contents, flat
//  trg_enb_out         out  1                 trigger enable
//  data_trans_enb_out  out  1                 data transfer enable
//  cmd_rst_out         out  1                 command reset pulse
//  cycled_trg_bgn_out  out  1                 cycled-trigger start pulse
//  shadow_pend_out     out  1                 shadow differs from active (macro only, else 0)
//  config_received_out out  16                accepted-write counter
//  wr_err_cnt_out      out  16                rejected-write counter
// BEHAVIOUR
//  - Reset (async, rst_n_in=0):
//    - registers = RST_VAL; all 1-bit outputs = 0; counters = 0; rd_data_out = 0.
//    - An in-flight pulse is cleared immediately.
//  - Address decode: idx = addr - BASE_ADDR; in range iff BASE_ADDR <= addr < BASE_ADDR+REG_NUM.
//  - Write cycle (wr_in=1):
//    - Accepted iff in range AND NOT (LOCK_MASK[idx] & trg_enb_out).
//    - Accepted: register updates at the clock edge; config_received_out+1.
//    - Rejected: no register changes; wr_err_cnt_out+1.
//    - Both counters wrap at 16'hFFFF -> 0.
//  - CTRL (idx 0) accepted write sets the enables next cycle; other values change only the register:
//    - 0x0001 -> trg_enb=1; 0x0000 -> trg_enb=0.
//    - 0x0002 -> data_trans_enb=1; 0x0003 -> data_trans_enb=0.
//  - CMD (idx 1) accepted write:
//    - 0x0055 starts cmd_rst_out; 0x0060 starts cycled_trg_bgn_out.
//    - Pulse rises the cycle after the write, is high exactly PULSE_LEN cycles, then returns to 0.
//    - Each pulse has its own counter.
//    - A repeat code while its pulse is high is not retriggered; the write is still counted as accepted.
//  - Read: rd_in in cycle N -> rd_data_out, rd_valid_out=1 in cycle N+1.
//    - Out of range: data 0, rd_err_out=1.
//    - Same-cycle write to the same index: read returns the pre-write value.
// CONFIGURATION
//  CFG_SHADOW_EN defined:
//    - Writes to idx>=2 load a shadow bank; active regs_out is unchanged.
//    - CMD 0x00AA (commit) copies all shadow to active in one cycle; regs_out changes the cycle
//      after the commit write.
//    - Commit while trg_enb_out=1 is rejected (counted in wr_err_cnt_out).
//    - Shadow resets to RST_VAL.
//    - shadow_pend_out=1 from an accepted shadow write until the commit edge.
//  CFG_SHADOW_EN undefined:
//    - Writes go directly to active registers.
//    - 0x00AA is an ordinary CMD value with no side effect.
//    - shadow_pend_out tied to 0.
// TESTING
//  T1 reset:
//    - Release rst_n_in -> regs_out=RST_VAL, all flags 0, counters 0.
//    - Assert rst_n_in mid-pulse -> pulse low same cycle.
//  T2 write/read:
//    - Write 0x1234 at 8'h0A -> config_received_out=1.
//    - Read 8'h0A -> 0x1234, valid 1 cycle later.
//    - Read 8'h20 -> rd_err_out=1, data 0.
//  T3 lock:
//    - CTRL=0x0001, write 0xBEEF to 8'h04 -> reg unchanged, wr_err_cnt_out=1.
//    - CTRL=0x0000, rewrite -> reg=0xBEEF.
//  T4 pulse:
//    - CMD=0x0055 -> cmd_rst_out high exactly 50 cycles.
//    - Re-send at cycle 20 -> still 50 total.
//    - 0x0060 overlapping -> independent pulse.
//  T5 range/wrap:
//    - Write 8'h01 and 8'h16 -> both rejected.
//    - Preload wr_err_cnt_out via 65535 errors -> next error gives 0.
//  T6 shadow (macro on):
//    - Write 0x00C3 to 8'h06 -> regs_out unchanged, shadow_pend_out=1.
//    - CMD 0x00AA -> next cycle regs_out idx4=0x00C3, pend=0.

Source files
------------

// File: rtl/config_reg_bank.sv
// Trigger-board configuration register bank: host write decode, registered readback,
// enables, fixed-length command pulses and write counters. Optional macro CFG_SHADOW_EN.
module config_reg_bank #(
    parameter int                          DATA_W    = 16,
    parameter int                          ADDR_W    = 8,
    parameter int                          REG_NUM   = 20,
    parameter logic [ADDR_W-1:0]           BASE_ADDR = 8'h02,
    parameter int                          PULSE_LEN = 50,
    parameter logic [REG_NUM-1:0]          LOCK_MASK = 20'h000FC,
    parameter logic [REG_NUM*DATA_W-1:0]   RST_VAL   = '0
) (
    input  logic                        clk_in,
    input  logic                        rst_n_in,
    input  logic                        wr_in,
    input  logic [ADDR_W-1:0]           wr_addr_in,
    input  logic [DATA_W-1:0]           data_in,
    input  logic                        rd_in,
    input  logic [ADDR_W-1:0]           rd_addr_in,
    output logic [DATA_W-1:0]           rd_data_out,
    output logic                        rd_valid_out,
    output logic                        rd_err_out,
    output logic [REG_NUM*DATA_W-1:0]   regs_out,
    output logic                        trg_enb_out,
    output logic                        data_trans_enb_out,
    output logic                        cmd_rst_out,
    output logic                        cycled_trg_bgn_out,
    output logic                        shadow_pend_out,
    output logic [15:0]                 config_received_out,
    output logic [15:0]                 wr_err_cnt_out
);

    localparam int          IDX_W     = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;
    localparam int unsigned ADDR_LO   = BASE_ADDR;
    localparam int unsigned ADDR_HI   = ADDR_LO + REG_NUM;
    localparam logic [7:0]  PULSE_CNT = 8'(PULSE_LEN);

    localparam logic [IDX_W-1:0]  IDX_CTRL = '0;
    localparam logic [IDX_W-1:0]  IDX_CMD  = IDX_W'(1);

    localparam logic [DATA_W-1:0] CTRL_TRG_ON  = DATA_W'(16'h0001);
    localparam logic [DATA_W-1:0] CTRL_TRG_OFF = DATA_W'(16'h0000);
    localparam logic [DATA_W-1:0] CTRL_DTE_ON  = DATA_W'(16'h0002);
    localparam logic [DATA_W-1:0] CTRL_DTE_OFF = DATA_W'(16'h0003);
    localparam logic [DATA_W-1:0] CMD_RST      = DATA_W'(16'h0055);
    localparam logic [DATA_W-1:0] CMD_CYC      = DATA_W'(16'h0060);

    function automatic logic addr_hit(input logic [ADDR_W-1:0] a);
        addr_hit = (32'(a) >= ADDR_LO) && (32'(a) < ADDR_HI);
    endfunction

    function automatic logic [IDX_W-1:0] addr_idx(input logic [ADDR_W-1:0] a);
        addr_idx = IDX_W'(a - BASE_ADDR);
    endfunction

    logic [REG_NUM-1:0][DATA_W-1:0] act;
    logic [7:0]       rst_cnt;
    logic [7:0]       cyc_cnt;
    logic             w_hit;
    logic [IDX_W-1:0] w_idx;
    logic             w_data_reg;
    logic             w_locked;
    logic             wr_ok;
    logic             wr_rej;
    logic             start_rst;
    logic             start_cyc;
    logic             rd_hit;
    logic [IDX_W-1:0] r_idx;

    assign w_hit      = addr_hit(wr_addr_in);
    assign w_idx      = addr_idx(wr_addr_in);
    assign w_data_reg = (w_idx != IDX_CTRL) && (w_idx != IDX_CMD);
    // CTRL and CMD are never locked, whatever the mask says for them.
    assign w_locked   = w_hit && w_data_reg && LOCK_MASK[w_idx] && trg_enb_out;

`ifdef CFG_SHADOW_EN
    localparam logic [DATA_W-1:0] CMD_COMMIT = DATA_W'(16'h00AA);

    logic [REG_NUM-1:0][DATA_W-1:0] shadow;
    logic                           is_commit;
    logic                           pend;

    assign is_commit = w_hit && (w_idx == IDX_CMD) && (data_in == CMD_COMMIT);
    assign wr_ok     = wr_in && w_hit && !w_locked && !(is_commit && trg_enb_out);
`else
    assign wr_ok     = wr_in && w_hit && !w_locked;
`endif
    assign wr_rej    = wr_in && !wr_ok;

    assign start_rst = wr_ok && (w_idx == IDX_CMD) && (data_in == CMD_RST) && (rst_cnt == '0);
    assign start_cyc = wr_ok && (w_idx == IDX_CMD) && (data_in == CMD_CYC) && (cyc_cnt == '0);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            act                 <= RST_VAL;
            trg_enb_out         <= 1'b0;
            data_trans_enb_out  <= 1'b0;
            config_received_out <= '0;
            wr_err_cnt_out      <= '0;
        end else begin
            if (wr_ok) begin
                config_received_out <= config_received_out + 16'd1;
                if (w_idx == IDX_CTRL) begin
                    act[IDX_CTRL] <= data_in;
                    case (data_in)
                        CTRL_TRG_ON:  trg_enb_out        <= 1'b1;
                        CTRL_TRG_OFF: trg_enb_out        <= 1'b0;
                        CTRL_DTE_ON:  data_trans_enb_out <= 1'b1;
                        CTRL_DTE_OFF: data_trans_enb_out <= 1'b0;
                        default: ;
                    endcase
                end else if (w_idx == IDX_CMD) begin
                    act[IDX_CMD] <= data_in;
`ifdef CFG_SHADOW_EN
                    if (is_commit) begin
                        for (int i = 2; i < REG_NUM; i++) act[i] <= shadow[i];
                    end
`endif
                end else begin
`ifndef CFG_SHADOW_EN
                    act[w_idx] <= data_in;
`endif
                end
            end
            if (wr_rej) wr_err_cnt_out <= wr_err_cnt_out + 16'd1;
        end
    end

`ifdef CFG_SHADOW_EN
    // Data registers are staged here and only reach regs_out on a commit.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            shadow <= RST_VAL;
            pend   <= 1'b0;
        end else if (wr_ok) begin
            if (w_data_reg) begin
                shadow[w_idx] <= data_in;
                pend          <= 1'b1;
            end else if (is_commit) begin
                pend          <= 1'b0;
            end
        end
    end

    assign shadow_pend_out = pend;
`else
    assign shadow_pend_out = 1'b0;
`endif

    // Command pulses: a non-zero count means the pulse is high, so reset drops it at once.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rst_cnt <= '0;
            cyc_cnt <= '0;
        end else begin
            if (start_rst)            rst_cnt <= PULSE_CNT;
            else if (rst_cnt != '0)   rst_cnt <= rst_cnt - 8'd1;
            if (start_cyc)            cyc_cnt <= PULSE_CNT;
            else if (cyc_cnt != '0)   cyc_cnt <= cyc_cnt - 8'd1;
        end
    end

    assign cmd_rst_out        = (rst_cnt != '0);
    assign cycled_trg_bgn_out = (cyc_cnt != '0);

    assign rd_hit = addr_hit(rd_addr_in);
    assign r_idx  = addr_idx(rd_addr_in);

    // Reads sample the active bank before any same-cycle write lands.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            rd_data_out  <= '0;
            rd_valid_out <= 1'b0;
            rd_err_out   <= 1'b0;
        end else begin
            rd_valid_out <= rd_in;
            rd_err_out   <= rd_in && !rd_hit;
            if (rd_in) rd_data_out <= rd_hit ? act[r_idx] : '0;
        end
    end

    assign regs_out = act;

endmodule

// File: tb/tb_config_reg_bank.sv
// Randomised bench for config_reg_bank against an array/timestamp reference model.
// Honours CFG_SHADOW_EN the same way the design does.
module tb_config_reg_bank;

    localparam int          NREG = 20;
    localparam int          BASE = 2;
    localparam int          PLEN = 50;
    localparam logic [19:0] LOCK = 20'h000FC;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        wr_in;
    logic [7:0]  wr_addr_in;
    logic [15:0] data_in;
    logic        rd_in;
    logic [7:0]  rd_addr_in;
    logic [15:0] rd_data_out;
    logic        rd_valid_out;
    logic        rd_err_out;
    logic [NREG*16-1:0] regs_out;
    logic        trg_enb_out;
    logic        data_trans_enb_out;
    logic        cmd_rst_out;
    logic        cycled_trg_bgn_out;
    logic        shadow_pend_out;
    logic [15:0] config_received_out;
    logic [15:0] wr_err_cnt_out;

    config_reg_bank dut (
        .clk_in(clk_in), .rst_n_in(rst_n_in),
        .wr_in(wr_in), .wr_addr_in(wr_addr_in), .data_in(data_in),
        .rd_in(rd_in), .rd_addr_in(rd_addr_in),
        .rd_data_out(rd_data_out), .rd_valid_out(rd_valid_out), .rd_err_out(rd_err_out),
        .regs_out(regs_out), .trg_enb_out(trg_enb_out),
        .data_trans_enb_out(data_trans_enb_out), .cmd_rst_out(cmd_rst_out),
        .cycled_trg_bgn_out(cycled_trg_bgn_out), .shadow_pend_out(shadow_pend_out),
        .config_received_out(config_received_out), .wr_err_cnt_out(wr_err_cnt_out)
    );

    always #5 clk_in = ~clk_in;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: register arrays, flags, and pulse start timestamps (edge numbers).
    logic [15:0] m_act [NREG];
    logic [15:0] m_sh  [NREG];
    bit          m_trg, m_dte, m_pend;
    logic [15:0] m_ok, m_err;
    int          edge_n, rst_at, cyc_at;
    bit          e_rv, e_rerr;
    logic [15:0] e_rd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit pulse_on(input int at, input int e);
        return (e >= at) && (e < at + PLEN);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) begin
            m_act[i] = '0;
            m_sh[i]  = '0;
        end
        m_trg = 0; m_dte = 0; m_pend = 0;
        m_ok = '0; m_err = '0;
        rst_at = -1000; cyc_at = -1000;
        e_rv = 0; e_rerr = 0; e_rd = '0;
    endtask

    task automatic model_edge(input bit w, input logic [7:0] wa, input logic [15:0] wd,
                              input bit r, input logic [7:0] ra);
        int  idx;
        int  prev;
        bit  ok;
        bit  rin;
        rin  = (int'(ra) >= BASE) && (int'(ra) < BASE + NREG);
        e_rv = r;
        e_rerr = r && !rin;
        if (r) e_rd = rin ? m_act[int'(ra) - BASE] : 16'h0;
        prev = edge_n;
        edge_n++;
        if (w) begin
            idx = int'(wa) - BASE;
            ok  = (idx >= 0) && (idx < NREG);
            if (ok && idx >= 2 && LOCK[idx] && m_trg) ok = 0;
`ifdef CFG_SHADOW_EN
            if (idx == 1 && wd == 16'h00AA && m_trg) ok = 0;
`endif
            if (!ok) m_err++;
            else begin
                m_ok++;
                if (idx == 0) begin
                    m_act[0] = wd;
                    if (wd == 16'h0001) m_trg = 1;
                    if (wd == 16'h0000) m_trg = 0;
                    if (wd == 16'h0002) m_dte = 1;
                    if (wd == 16'h0003) m_dte = 0;
                end else if (idx == 1) begin
                    m_act[1] = wd;
                    if (wd == 16'h0055 && !pulse_on(rst_at, prev)) rst_at = edge_n;
                    if (wd == 16'h0060 && !pulse_on(cyc_at, prev)) cyc_at = edge_n;
`ifdef CFG_SHADOW_EN
                    if (wd == 16'h00AA) begin
                        for (int i = 2; i < NREG; i++) m_act[i] = m_sh[i];
                        m_pend = 0;
                    end
`endif
                end else begin
`ifdef CFG_SHADOW_EN
                    m_sh[idx] = wd;
                    m_pend = 1;
`else
                    m_act[idx] = wd;
`endif
                end
            end
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < NREG; i++)
            check($sformatf("regs[%0d]", i), 32'(regs_out[i*16 +: 16]), 32'(m_act[i]));
        check("trg_enb", 32'(trg_enb_out), 32'(m_trg));
        check("dte", 32'(data_trans_enb_out), 32'(m_dte));
        check("cmd_rst", 32'(cmd_rst_out), 32'(pulse_on(rst_at, edge_n)));
        check("cyc_bgn", 32'(cycled_trg_bgn_out), 32'(pulse_on(cyc_at, edge_n)));
        check("cfg_rcv", 32'(config_received_out), 32'(m_ok));
        check("wr_err", 32'(wr_err_cnt_out), 32'(m_err));
        check("pend", 32'(shadow_pend_out), 32'(m_pend));
        check("rd_valid", 32'(rd_valid_out), 32'(e_rv));
        if (e_rv) begin
            check("rd_data", 32'(rd_data_out), 32'(e_rd));
            check("rd_err", 32'(rd_err_out), 32'(e_rerr));
        end
    endtask

    task automatic cycle(input bit w, input logic [7:0] wa, input logic [15:0] wd,
                         input bit r, input logic [7:0] ra, input bit do_chk);
        wr_in = w; wr_addr_in = wa; data_in = wd;
        rd_in = r; rd_addr_in = ra;
        @(posedge clk_in);
        model_edge(w, wa, wd, r, ra);
        #1;
        if (do_chk) compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(0, 8'h00, 16'h0000, 0, 8'h00, 1);
    endtask

    function automatic logic [15:0] rand_data();
        logic [15:0] codes [8];
        codes = '{16'h0001, 16'h0000, 16'h0002, 16'h0003,
                  16'h0055, 16'h0060, 16'h00AA, 16'h0000};
        if ($urandom_range(0, 2) == 0) return 16'($urandom);
        return codes[$urandom_range(0, 7)];
    endfunction

    function automatic logic [7:0] rand_addr();
        if ($urandom_range(0, 4) == 0) return 8'($urandom);
        return 8'($urandom_range(BASE, BASE + NREG - 1));
    endfunction

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int rst_hits;
        int cyc_hits;
        edge_n = 0;
        model_reset();
        rst_n_in = 0; wr_in = 0; wr_addr_in = '0; data_in = '0; rd_in = 0; rd_addr_in = '0;
        repeat (3) @(posedge clk_in);
        #1;
        compare_all();
        @(negedge clk_in);
        rst_n_in = 1;
        idle(2);

        // Basic write / read / out-of-range read
        cycle(1, 8'h0A, 16'h1234, 0, 8'h00, 1);
        check("t2_cfg_rcv", 32'(config_received_out), 32'd1);
        cycle(0, 8'h00, 16'h0000, 1, 8'h0A, 1);
        check("t2_rd_valid", 32'(rd_valid_out), 32'd1);
        check("t2_rd_data", 32'(rd_data_out), 32'h1234);
        cycle(0, 8'h00, 16'h0000, 1, 8'h20, 1);
        check("t2_rd_err", 32'(rd_err_out), 32'd1);
        check("t2_rd_err_data", 32'(rd_data_out), 32'd0);
        idle(1);
        check("t2_valid_pulse", 32'(rd_valid_out), 32'd0);
        // Same-cycle read and write to one register
        cycle(1, 8'h0A, 16'h5678, 1, 8'h0A, 1);
        check("t2_rd_prewrite", 32'(rd_data_out), 32'h1234);

        // Lock while triggering
        cycle(1, 8'h02, 16'h0001, 0, 8'h00, 1);
        cycle(1, 8'h04, 16'hBEEF, 0, 8'h00, 1);
        check("t3_locked_err", 32'(wr_err_cnt_out), 32'd1);
        check("t3_locked_reg", 32'(regs_out[2*16 +: 16]), 32'h0000);
        cycle(1, 8'h02, 16'h0000, 0, 8'h00, 1);
        cycle(1, 8'h04, 16'hBEEF, 0, 8'h00, 1);
`ifndef CFG_SHADOW_EN
        check("t3_unlocked_reg", 32'(regs_out[2*16 +: 16]), 32'hBEEF);
`endif

        // Pulses: resend mid-pulse, overlapping independent pulse
        cycle(1, 8'h03, 16'h0055, 0, 8'h00, 1);
        rst_hits = int'(cmd_rst_out);
        cyc_hits = 0;
        for (int k = 1; k < 90; k++) begin
            if (k == 19)      cycle(1, 8'h03, 16'h0055, 0, 8'h00, 1);
            else if (k == 29) cycle(1, 8'h03, 16'h0060, 0, 8'h00, 1);
            else              cycle(0, 8'h00, 16'h0000, 0, 8'h00, 1);
            rst_hits += int'(cmd_rst_out);
            cyc_hits += int'(cycled_trg_bgn_out);
        end
        check("t4_rst_len", 32'(rst_hits), 32'(PLEN));
        check("t4_cyc_len", 32'(cyc_hits), 32'(PLEN));

        // Range rejects and error-counter wrap
        cycle(1, 8'h01, 16'h1111, 0, 8'h00, 1);
        cycle(1, 8'h16, 16'h2222, 0, 8'h00, 1);
        check("t5_range_err", 32'(wr_err_cnt_out), 32'd3);
        while (m_err != 16'hFFFF) cycle(1, 8'h01, 16'h0000, 0, 8'h00, 0);
        #1;
        compare_all();
        check("t5_err_max", 32'(wr_err_cnt_out), 32'hFFFF);
        cycle(1, 8'hF0, 16'h0000, 0, 8'h00, 1);
        check("t5_err_wrap", 32'(wr_err_cnt_out), 32'd0);

`ifdef CFG_SHADOW_EN
        cycle(1, 8'h06, 16'h00C3, 0, 8'h00, 1);
        check("t6_active_held", 32'(regs_out[4*16 +: 16]), 32'h0000);
        check("t6_pend_set", 32'(shadow_pend_out), 32'd1);
        cycle(1, 8'h03, 16'h00AA, 0, 8'h00, 1);
        check("t6_committed", 32'(regs_out[4*16 +: 16]), 32'h00C3);
        check("t6_pend_clr", 32'(shadow_pend_out), 32'd0);
`endif

        // Randomised traffic
        for (int n = 0; n < 3000; n++)
            cycle(1'($urandom), rand_addr(), rand_data(), 1'($urandom), rand_addr(), 1);

        // Reset in the middle of a pulse
        idle(PLEN + 2);
        cycle(1, 8'h03, 16'h0055, 0, 8'h00, 1);
        idle(10);
        check("t1_pulse_before_rst", 32'(cmd_rst_out), 32'd1);
        #3;
        rst_n_in = 0;
        #1;
        check("t1_pulse_async_clr", 32'(cmd_rst_out), 32'd0);
        model_reset();
        compare_all();
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        rst_n_in = 1;
        idle(3);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
